// File: rtl/vend_pkg.sv
// Shared definitions for the candy vending controller.
//   - Coin codes presented on the `in` port of candy_vend_fsm.
//   - Status codes driven on the `out` port.
//   - State enum with a fixed 4-bit encoding so the state register is easy
//     to read in a debugger or logic analyser.
//   - Helpers that map between balance states and cent values.
package vend_pkg;

  // Coin codes. 00 doubles as "no coin" / cancel request.
  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_CANCEL = 2'b00;
  localparam logic [1:0] COIN_5      = 2'b01;
  localparam logic [1:0] COIN_10     = 2'b10;
  localparam logic [1:0] COIN_25     = 2'b11;

  // Status codes.
  localparam logic [1:0] ST_INSUF    = 2'b00;
  localparam logic [1:0] ST_DISP     = 2'b01;
  localparam logic [1:0] ST_DISP_CHG = 2'b10;
  localparam logic [1:0] ST_CANCEL   = 2'b11;

  // Candy price in cents. Six bits cover the largest sum (25 + 25 = 50).
  localparam logic [5:0] PRICE = 6'd30;

  typedef enum logic [3:0] {
    S0       = 4'd0,
    S5       = 4'd1,
    S10      = 4'd2,
    S15      = 4'd3,
    S20      = 4'd4,
    S25      = 4'd5,
    DISP     = 4'd6,
    DISP_CHG = 4'd7,
    CANCEL   = 4'd8
  } state_t;

  // Balance state holding `cents`. Only called with values below PRICE that
  // are multiples of 5; anything else falls back to S0.
  function automatic state_t balance_state(input logic [5:0] cents);
    state_t s;
    case (cents)
      6'd5:    s = S5;
      6'd10:   s = S10;
      6'd15:   s = S15;
      6'd20:   s = S20;
      6'd25:   s = S25;
      default: s = S0;
    endcase
    return s;
  endfunction

  // Moore output for a state. Balance and illegal states report ST_INSUF.
  function automatic logic [1:0] status_of(input state_t s);
    logic [1:0] st;
    case (s)
      DISP:     st = ST_DISP;
      DISP_CHG: st = ST_DISP_CHG;
      CANCEL:   st = ST_CANCEL;
      default:  st = ST_INSUF;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/candy_vend_fsm_coin_decode.sv
// Coin decoder: turns the 2-bit coin code into its cent value and flags the
// cancel request.
// Ports:
//   code   in  2  coin code (00 cancel, 01 5c, 10 10c, 11 25c)
//   cents  out 6  coin value in cents (0 for cancel)
//   cancel out 1  high when code is the cancel request
module coin_decode
  import vend_pkg::*;
(
  input  logic [1:0] code,
  output logic [5:0] cents,
  output logic       cancel
);

  always_comb begin
    cents  = 6'd0;
    cancel = 1'b0;
    case (code)
      COIN_5:  cents = 6'd5;
      COIN_10: cents = 6'd10;
      COIN_25: cents = 6'd25;
      default: cancel = 1'b1;
    endcase
  end

endmodule

// File: rtl/candy_vend_fsm.sv
// Candy vending controller (price 30c). Accumulates 5/10/25c coins, one per
// confirmed clock, and reports dispense, dispense-with-change or cancel on a
// registered 2-bit status output. Dispense/cancel states last one cycle and
// count as zero balance, so a coin arriving during them starts a new
// purchase.
// Ports:
//   clk     in  1  system clock, rising edge
//   rst_n   in  1  asynchronous active-low reset
//   in      in  2  coin code (00 cancel, 01 5c, 10 10c, 11 25c)
//   confirm in  1  qualifies `in` on the sampling edge
//   out     out 2  status (00 insufficient/idle, 01 dispense,
//                  10 dispense + change, 11 cancel/refund)
module candy_vend_fsm
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] in,
  input  logic       confirm,
  output logic [1:0] out
);

  state_t     state_reg;
  state_t     state_next;
  logic [1:0] out_reg;

  logic [5:0] coin_cents;
  logic       coin_cancel;

  coin_decode u_coin_decode (
    .code   (in),
    .cents  (coin_cents),
    .cancel (coin_cancel)
  );

  // Next-state logic.
  logic [5:0] balance;     // effective balance B
  logic       in_balance;  // current state is a balance state
  logic       illegal;     // encodings 9..15
  logic [5:0] sum;

  always_comb begin
    state_next = state_reg;
    balance    = 6'd0;
    in_balance = 1'b0;
    illegal    = 1'b0;
    sum        = 6'd0;

    case (state_reg)
      S0:  begin balance = 6'd0;  in_balance = 1'b1; end
      S5:  begin balance = 6'd5;  in_balance = 1'b1; end
      S10: begin balance = 6'd10; in_balance = 1'b1; end
      S15: begin balance = 6'd15; in_balance = 1'b1; end
      S20: begin balance = 6'd20; in_balance = 1'b1; end
      S25: begin balance = 6'd25; in_balance = 1'b1; end
      DISP, DISP_CHG, CANCEL: balance = 6'd0;
      default: illegal = 1'b1;
    endcase

    sum = balance + coin_cents;

    if (illegal) begin
      state_next = S0;
    end else if (confirm) begin
      if (coin_cancel) begin
        state_next = (balance != 6'd0) ? CANCEL : S0;
      end else if (sum < PRICE) begin
        state_next = balance_state(sum);
      end else if (sum == PRICE) begin
        state_next = DISP;
      end else begin
        state_next = DISP_CHG;
      end
    end else begin
      // Without a confirmed code, balances hold and transients expire.
      state_next = in_balance ? state_reg : S0;
    end
  end

  // The status is registered from the next state, so `out` is driven
  // straight from a flop and always matches the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S0;
      out_reg   <= ST_INSUF;
    end else begin
      state_reg <= state_next;
      out_reg   <= status_of(state_next);
    end
  end

  assign out = out_reg;

endmodule

// File: tb/tb_candy_vend_fsm.sv
// Self-checking bench for candy_vend_fsm. The driver applies one code per
// cycle and pushes the status a cents-level purchase model predicts; a
// separate monitor pops and compares one cycle-status per clock.
module tb_candy_vend_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] in = 2'b00;
  logic       confirm = 1'b0;
  logic [1:0] out;

  candy_vend_fsm dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .confirm (confirm),
    .out     (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] code;
    logic       conf;
    logic [1:0] status;
    int         bal;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  // Reference model: balance in cents. After a dispense or cancel the
  // balance is simply zero, which is all a following coin needs to see.
  int model_bal = 0;

  function automatic int coin_value(input logic [1:0] code);
    case (code)
      2'b01:   return 5;
      2'b10:   return 10;
      2'b11:   return 25;
      default: return 0;
    endcase
  endfunction

  task automatic step(input logic [1:0] code, input logic conf);
    exp_t e;
    int   n;
    @(negedge clk);
    in      = code;
    confirm = conf;
    e.code  = code;
    e.conf  = conf;
    e.status = 2'b00;
    if (conf) begin
      if (code == 2'b00) begin
        e.status  = (model_bal > 0) ? 2'b11 : 2'b00;
        model_bal = 0;
      end else begin
        n = model_bal + coin_value(code);
        if (n < 30) begin
          model_bal = n;
        end else begin
          e.status  = (n == 30) ? 2'b01 : 2'b10;
          model_bal = 0;
        end
      end
    end
    e.bal = model_bal;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic check_now(input string name, input logic [1:0] want);
    checks++;
    if (out !== want) begin
      errors++;
      $display("FAIL %s: out=%b expected=%b", name, out, want);
    end
  endtask

  // Monitor: the status is valid every cycle, so one pop per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        checks++;
        if (out !== e.status) begin
          errors++;
          $display("FAIL txn %0d: in=%b confirm=%b out=%b expected=%b",
                   txn, e.code, e.conf, out, e.status);
        end else begin
          $display("txn %0d: in=%b confirm=%b out=%b balance=%0d",
                   txn, e.code, e.conf, out, e.bal);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    logic [1:0] rc;

    // Power-on reset.
    #1;
    check_now("por", 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-purchase at balance 15, then one 10c coin.
    step(2'b01, 1'b1);
    step(2'b10, 1'b1);
    #4;
    rst_n = 1'b0;
    model_bal = 0;
    #1;
    check_now("async_reset", 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b10, 1'b1);

    // Clean start.
    step(2'b00, 1'b1);
    // Exact payment 5,5,10,10 then idle code.
    step(2'b01, 1'b1); step(2'b01, 1'b1); step(2'b10, 1'b1); step(2'b10, 1'b1);
    step(2'b00, 1'b1);
    // 25 then 5 -> dispense; 10 then 25 -> dispense with change.
    step(2'b11, 1'b1); step(2'b01, 1'b1);
    step(2'b10, 1'b1); step(2'b11, 1'b1);
    step(2'b00, 1'b1);
    // Insufficient 5,5,5 then cancel; cancel at zero balance.
    step(2'b01, 1'b1); step(2'b01, 1'b1); step(2'b01, 1'b1);
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);
    // 5,10 cancel.
    step(2'b01, 1'b1); step(2'b10, 1'b1); step(2'b00, 1'b1); step(2'b00, 1'b0);
    // Long mixed sequence.
    step(2'b10, 1'b1); step(2'b10, 1'b1); step(2'b10, 1'b1);
    step(2'b01, 1'b1); step(2'b10, 1'b1); step(2'b11, 1'b1);
    step(2'b01, 1'b1); step(2'b10, 1'b1); step(2'b00, 1'b1);
    // confirm=0 holds balance and ignores coins; then finish the purchase.
    step(2'b10, 1'b1);
    step(2'b11, 1'b0); step(2'b00, 1'b0); step(2'b01, 1'b0);
    step(2'b10, 1'b1); step(2'b10, 1'b1);
    // Transient state expiring with confirm=0.
    step(2'b11, 1'b1); step(2'b01, 1'b1); step(2'b11, 1'b0);

    // Randomized traffic, confirm high most of the time.
    for (int i = 0; i < 300; i++) begin
      rc = 2'($urandom_range(0, 3));
      step(rc, ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0);
    end

    // Let the monitor drain the queue, bounded.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
